// File: rtl/jelly_axi4s_video_frame_aligner_pkg.sv
// Shared types and helpers for the multi-channel video frame aligner.
//   state_t     : aligner FSM state (IDLE / SYNC / RUN)
//   err_sat_inc : saturating increment for counters up to 32 bits wide
package jelly_axi4s_video_frame_aligner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] err_sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/jelly_axi4s_skid_reg.sv
// Output stage for the frame aligner.
//   M_REGS != 0 : registered output with a 2-entry skid buffer; full throughput
//                 under continuous ready, s_ready is a pure register output.
//   M_REGS == 0 : combinational pass-through.
// Ports:
//   aclk, aresetn (sync, active low), aclken (freezes state when 0)
//   s_data/s_valid/s_ready : upstream side
//   m_data/m_valid/m_ready : downstream side
module jelly_axi4s_skid_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned M_REGS = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  generate
    if (M_REGS != 0) begin : g_reg
      logic [WIDTH-1:0] main_data_q, main_data_d;
      logic [WIDTH-1:0] skid_data_q, skid_data_d;
      logic             main_valid_q, main_valid_d;
      logic             skid_valid_q, skid_valid_d;

      always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || m_ready) begin
          // Main register frees up: refill from skid first, else from input.
          if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = s_valid;
            if (s_valid) begin
              main_data_d = s_data;
            end
          end
        end else if (s_valid && !skid_valid_q) begin
          // Downstream stalled: park the accepted beat in the skid entry.
          skid_data_d  = s_data;
          skid_valid_d = 1'b1;
        end
      end

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          main_data_q  <= '0;
          main_valid_q <= 1'b0;
          skid_data_q  <= '0;
          skid_valid_q <= 1'b0;
        end else if (aclken) begin
          main_data_q  <= main_data_d;
          main_valid_q <= main_valid_d;
          skid_data_q  <= skid_data_d;
          skid_valid_q <= skid_valid_d;
        end
      end

      assign s_ready = !skid_valid_q;
      assign m_data  = main_data_q;
      assign m_valid = main_valid_q;
    end else begin : g_pass
      assign s_ready = m_ready;
      assign m_data  = s_data;
      assign m_valid = s_valid;
    end
  endgenerate

endmodule

// File: rtl/jelly_axi4s_video_frame_aligner.sv
// Frame-synchronising combiner for NUM AXI4-Stream video inputs.
// Each enabled input is held at its frame-start beat (tuser[0]=1) until all
// enabled inputs are there, then beats are merged one-for-one into a single
// wide stream. tuser[0]/tlast disagreement drops back to SYNC and bumps a
// saturating error counter.
// Ports:
//   aclk, aresetn (sync, active low), aclken (clock enable)
//   ctl_enable   : channel mask, latched on SYNC entry
//   ctl_resync   : pulse, forces RUN back to SYNC
//   stat_synced  : high in RUN; stat_enable: latched mask; stat_err_count
//   s_axi4s_*    : NUM packed input streams
//   m_axi4s_*    : merged output, lane i at tdata[i*TDATA_WIDTH +: TDATA_WIDTH]
module jelly_axi4s_video_frame_aligner
  import jelly_axi4s_video_frame_aligner_pkg::*;
#(
  parameter int unsigned NUM         = 3,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned M_REGS      = 1,
  parameter int unsigned ERR_WIDTH   = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         aclken,

  input  logic [NUM-1:0]               ctl_enable,
  input  logic                         ctl_resync,
  output logic                         stat_synced,
  output logic [NUM-1:0]               stat_enable,
  output logic [ERR_WIDTH-1:0]         stat_err_count,

  input  logic [NUM*TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic [NUM-1:0]               s_axi4s_tlast,
  input  logic [NUM*TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic [NUM-1:0]               s_axi4s_tvalid,
  output logic [NUM-1:0]               s_axi4s_tready,

  output logic [TUSER_WIDTH-1:0]       m_axi4s_tuser,
  output logic                         m_axi4s_tlast,
  output logic [NUM*TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                         m_axi4s_tvalid,
  input  logic                         m_axi4s_tready
);

  localparam int unsigned LANES_W = NUM * TDATA_WIDTH;
  localparam int unsigned PW      = TUSER_WIDTH + 1 + LANES_W;

  state_t               state_q, state_d;
  logic [NUM-1:0]       mask_q, mask_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;

  logic [NUM-1:0]         head_sof;
  logic                   all_held;
  logic                   all_valid;
  logic [LANES_W-1:0]     lane_data;
  logic [TUSER_WIDTH-1:0] ref_user;
  logic                   ref_last;
  logic                   ref_found;
  logic                   mismatch;
  logic [NUM-1:0]         s_tready_c;

  logic          fwd_valid;
  logic          fwd_ready;
  logic [PW-1:0] fwd_data;
  logic [PW-1:0] out_data;

  always_comb begin
    head_sof = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      head_sof[i] = s_axi4s_tvalid[i] & s_axi4s_tuser[i*TUSER_WIDTH];
    end
  end

  assign all_held  = &(head_sof | ~mask_q);
  assign all_valid = &(s_axi4s_tvalid | ~mask_q);

  // Lane packing plus comparison of every enabled channel's frame-start and
  // end-of-line flags against the lowest enabled channel.
  always_comb begin
    lane_data = '0;
    ref_user  = '0;
    ref_last  = 1'b0;
    ref_found = 1'b0;
    mismatch  = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (mask_q[i]) begin
        lane_data[i*TDATA_WIDTH +: TDATA_WIDTH] = s_axi4s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        if (!ref_found) begin
          ref_found = 1'b1;
          ref_user  = s_axi4s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
          ref_last  = s_axi4s_tlast[i];
        end else if ((s_axi4s_tuser[i*TUSER_WIDTH] != ref_user[0]) ||
                     (s_axi4s_tlast[i] != ref_last)) begin
          mismatch = 1'b1;
        end
      end
    end
  end

  assign fwd_data  = {ref_user, ref_last, lane_data};
  assign fwd_valid = aresetn && aclken && (state_q == RUN) && (mask_q != '0) &&
                     all_valid && !mismatch;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    err_d      = err_q;
    s_tready_c = '0;
    unique case (state_q)
      IDLE: begin
        s_tready_c = '1;
        mask_d     = ctl_enable;
        if (ctl_enable != '0) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        // Enabled channels discard until a frame-start beat is at the head.
        s_tready_c = ~mask_q | ~head_sof;
        if (mask_q == '0) begin
          state_d = IDLE;
        end else if (all_held) begin
          state_d = RUN;
        end
      end
      RUN: begin
        s_tready_c = ~mask_q;
        if (mask_q == '0) begin
          state_d = IDLE;
        end else if (all_valid && fwd_ready) begin
          if (mismatch) begin
            // Beat left in place; SYNC will discard it.
            err_d   = ERR_WIDTH'(err_sat_inc(32'(err_q), ERR_WIDTH));
            state_d = SYNC;
            mask_d  = ctl_enable;
          end else begin
            s_tready_c = '1;
            if (ctl_resync) begin
              state_d = SYNC;
              mask_d  = ctl_enable;
            end
          end
        end else if (ctl_resync) begin
          state_d = SYNC;
          mask_d  = ctl_enable;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      err_q   <= '0;
    end else if (aclken) begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign s_axi4s_tready = {NUM{aresetn & aclken}} & s_tready_c;

  jelly_axi4s_skid_reg #(
    .WIDTH  (PW),
    .M_REGS (M_REGS)
  ) u_out (
    .aclk    (aclk),
    .aresetn (aresetn),
    .aclken  (aclken),
    .s_data  (fwd_data),
    .s_valid (fwd_valid),
    .s_ready (fwd_ready),
    .m_data  (out_data),
    .m_valid (m_axi4s_tvalid),
    .m_ready (m_axi4s_tready)
  );

  assign m_axi4s_tuser  = out_data[PW-1 -: TUSER_WIDTH];
  assign m_axi4s_tlast  = out_data[LANES_W];
  assign m_axi4s_tdata  = out_data[LANES_W-1:0];

  assign stat_synced    = (state_q == RUN);
  assign stat_enable    = mask_q;
  assign stat_err_count = err_q;

endmodule
